bitrev_reorder: RTL

//  Output-side reorder buffer for the SDF FFT pipeline. The final SDF stage emits each
//  N-point frame in bit-reversed index order; this block captures a full frame and

---
 rtl/fft_pkg.sv | 21 ++
 rtl/reorder_ram.sv | 37 +++
 rtl/bitrev_reorder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the SDF FFT pipeline, its reorder buffer and benches.
//   LOGN convention: an N-point frame uses LOGN = $clog2(N) index bits.
//   bitrev(value, logn) reverses the low logn bits of value. Upper bits of the
//   result are zero. logn must be a constant (elaboration-time) when used in RTL.
package fft_pkg;

    localparam int BITREV_MAX_BITS = 32;

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int logn);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < BITREV_MAX_BITS; i++) begin
            if (i < logn) begin
                result[5'(i)] = value[5'(logn - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// reorder_ram
//   Simple dual-port RAM for the bit-reversal reorder buffer. One synchronous
//   write port and one registered read port, both on clk. Contents are not reset.
// Ports
//   clk      in  1   clock
//   wr_en    in  1   write strobe
//   wr_addr  in  AW  write address (MSB selects the ping-pong bank)
//   wr_data  in  DW  write data
//   rd_addr  in  AW  read address (MSB selects the ping-pong bank)
//   rd_data  out DW  data at rd_addr, registered on clk
module reorder_ram
    import fft_pkg::*;
#(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bitrev_reorder.sv
// bitrev_reorder
//   Output-side reorder buffer for the SDF FFT. Captures each N-point frame that
//   arrives in bit-reversed index order and replays it in natural order, using
//   two ping-pong banks so back-to-back frames stream without gaps.
//
//   Streaming convention (no back-pressure): enable_in is high for every cycle
//   that carries a valid input sample; a frame is N consecutive enabled cycles,
//   and dropping enable_in discards any partial frame. enable_out is high for
//   exactly the N cycles that carry X[0]..X[N-1] of a completed frame; out_re and
//   out_im are forced to 0 whenever enable_out is low.
// Ports
//   clk         in  1      clock, all logic on posedge
//   rst_n       in  1      synchronous active-low reset
//   enable_in   in  1      input sample valid
//   in_re       in  WIDTH  real part, bit-reversed order
//   in_im       in  WIDTH  imag part, bit-reversed order
//   enable_out  out 1      output sample valid
//   out_re      out WIDTH  real part, natural order
//   out_im      out WIDTH  imag part, natural order
module bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im
);

    localparam int              LOGN = $clog2(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [LOGN-1:0]    wr_cnt;
    logic [LOGN-1:0]    wr_addr;
    logic               wr_bank;
    logic               wr_en;
    logic [LOGN-1:0]    rd_cnt;
    logic               rd_bank;
    logic               rd_active;
    logic               rd_valid;
    logic               frame_done;
    logic [2*WIDTH-1:0] rd_data;

    // Last sample of a frame is being accepted this cycle.
    assign frame_done = enable_in && (wr_cnt == LAST);
    assign wr_addr    = LOGN'(bitrev(32'(wr_cnt), LOGN));
    assign wr_en      = enable_in && rst_n;

    // Write side: wr_cnt wraps naturally at N, so a following frame can start
    // on the very next cycle. A drop of enable_in restarts the count without
    // flipping the bank, so a partial frame is simply overwritten later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (enable_in) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
        end else begin
            wr_cnt <= '0;
        end
    end

    // Read side: a newly completed frame always takes priority, which gives a
    // seamless restart when it lands on the final read of the previous frame.
    // rd_valid tracks the address phase into the registered RAM output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_active <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_active;
            if (frame_done) begin
                rd_active <= 1'b1;
                rd_cnt    <= '0;
                rd_bank   <= wr_bank;
            end else if (rd_active) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end

    reorder_ram #(
        .AW(LOGN + 1),
        .DW(2 * WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr({wr_bank, wr_addr}),
        .wr_data({in_re, in_im}),
        .rd_addr({rd_bank, rd_cnt}),
        .rd_data(rd_data)
    );

    // Output stage: zero the data whenever no valid sample is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_out <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            enable_out <= rd_valid;
            out_re     <= rd_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
            out_im     <= rd_valid ? rd_data[WIDTH-1:0]       : '0;
        end
    end

endmodule
